// File: rtl/rob_retire_pkg.sv
// Shared types and constants for the reorder buffer / retirement slice.
// The entry layout is the storage format of one ROB slot.
package rob_retire_pkg;

    localparam int PREG_W   = 6;
    localparam int NUM_PREG = 1 << PREG_W;
    localparam int ARCH_W   = 5;

    localparam logic [ARCH_W-1:0] ARCH_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [ARCH_W-1:0] arch_reg;
        logic [PREG_W-1:0] new_phys;
        logic [PREG_W-1:0] old_phys;
        logic              regwr;
        logic              sys;
        logic [31:0]       pc;
    } rob_entry_t;

endpackage

// File: rtl/rob_retire_if.sv
// Rename/EXE-facing allocation, completion and retirement bundle of the ROB.
// The master side is the pipeline driving allocations and completions.
interface rob_retire_if #(
    parameter int TAG_W  = 4,
    parameter int PREG_W = 6
);
    import rob_retire_pkg::*;

    logic              alloc_valid;
    logic [ARCH_W-1:0] alloc_arch_reg;
    logic [PREG_W-1:0] alloc_new_phys;
    logic [PREG_W-1:0] alloc_old_phys;
    logic              alloc_regwr;
    logic              alloc_sys;
    logic [31:0]       alloc_pc;
    logic [TAG_W-1:0]  alloc_tag;
    logic              rob_halt;

    logic              complete_valid;
    logic [TAG_W-1:0]  complete_tag;

    logic [TAG_W-1:0]  head_tag;
    logic              commit_valid;
    logic [ARCH_W-1:0] commit_arch_reg;
    logic [PREG_W-1:0] commit_new_phys;
    logic              commit_remap;
    logic              free_valid;
    logic [PREG_W-1:0] free_phys;
    logic              commit_sys;
    logic [31:0]       commit_pc;

    modport master (
        output alloc_valid, alloc_arch_reg, alloc_new_phys, alloc_old_phys,
               alloc_regwr, alloc_sys, alloc_pc, complete_valid, complete_tag,
        input  alloc_tag, rob_halt, head_tag, commit_valid, commit_arch_reg,
               commit_new_phys, commit_remap, free_valid, free_phys,
               commit_sys, commit_pc
    );

    modport slave (
        input  alloc_valid, alloc_arch_reg, alloc_new_phys, alloc_old_phys,
               alloc_regwr, alloc_sys, alloc_pc, complete_valid, complete_tag,
        output alloc_tag, rob_halt, head_tag, commit_valid, commit_arch_reg,
               commit_new_phys, commit_remap, free_valid, free_phys,
               commit_sys, commit_pc
    );

endinterface

// File: rtl/rob_ptr_ctr.sv
// Wrap-around ring pointer: synchronous clear beats increment.
module rob_ptr_ctr #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            ptr <= '0;
        else if (clr)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + W'(1);
    end

endmodule

// File: rtl/rob_retire.sv
// In-order reorder buffer: one allocation, one completion and at most one
// retirement per cycle; retirements feed the RRAT and Rename's free list.
module rob_retire #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 4,
    parameter int PREG_W = 6
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         FLUSH,
    rob_retire_if.slave  rif
);
    import rob_retire_pkg::*;

    localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

    rob_entry_t          rob_q [DEPTH];
    logic [TAG_W-1:0]    head;
    logic [TAG_W-1:0]    tail;
    logic [TAG_W:0]      count_q;

    logic                alloc_fire;
    logic                retire_fire;
    rob_entry_t          head_e;

    logic                commit_vld_p1;
    logic [ARCH_W-1:0]   commit_arch_p1;
    logic [PREG_W-1:0]   commit_new_p1;
    logic                commit_remap_p1;
    logic [PREG_W-1:0]   free_phys_p1;
    logic                commit_sys_p1;
    logic [31:0]         commit_pc_p1;

    assign head_e       = rob_q[head];
    assign rif.rob_halt = (count_q == FULL);
    assign alloc_fire   = rif.alloc_valid && !rif.rob_halt;
    // Empty ring always has a cleared head slot, so no explicit count check.
    assign retire_fire  = head_e.valid && head_e.done;
    assign rif.alloc_tag = tail;
    assign rif.head_tag  = head;

    rob_ptr_ctr #(.W(TAG_W)) u_head (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (FLUSH),
        .inc   (retire_fire),
        .ptr   (head)
    );

    rob_ptr_ctr #(.W(TAG_W)) u_tail (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (FLUSH),
        .inc   (alloc_fire),
        .ptr   (tail)
    );

    // Entry storage: only valid/done are control; the payload is never reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i].valid <= 1'b0;
                rob_q[i].done  <= 1'b0;
            end
        end else if (FLUSH) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i].valid <= 1'b0;
                rob_q[i].done  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rif.complete_valid && rif.complete_tag == TAG_W'(i) && rob_q[i].valid)
                    rob_q[i].done <= 1'b1;
            end
            if (retire_fire)
                rob_q[head].valid <= 1'b0;
            // head==tail only when empty or full, so alloc never hits the retiring slot.
            if (alloc_fire)
                rob_q[tail] <= '{valid:    1'b1,
                                 done:     1'b0,
                                 arch_reg: rif.alloc_arch_reg,
                                 new_phys: rif.alloc_new_phys,
                                 old_phys: rif.alloc_old_phys,
                                 regwr:    rif.alloc_regwr,
                                 sys:      rif.alloc_sys,
                                 pc:       rif.alloc_pc};
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            count_q <= '0;
        else if (FLUSH)
            count_q <= '0;
        else begin
            case ({alloc_fire, retire_fire})
                2'b10:   count_q <= count_q + (TAG_W+1)'(1);
                2'b01:   count_q <= count_q - (TAG_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ---- p0 -> p1: retirement outputs, one-cycle pulses ----
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET || FLUSH) begin
            commit_vld_p1   <= 1'b0;
            commit_arch_p1  <= '0;
            commit_new_p1   <= '0;
            commit_remap_p1 <= 1'b0;
            free_phys_p1    <= '0;
            commit_sys_p1   <= 1'b0;
            commit_pc_p1    <= '0;
        end else begin
            commit_vld_p1   <= retire_fire;
            commit_arch_p1  <= retire_fire ? head_e.arch_reg : '0;
            commit_new_p1   <= retire_fire ? head_e.new_phys : '0;
            commit_remap_p1 <= retire_fire && head_e.regwr && (head_e.arch_reg != ARCH_ZERO);
            free_phys_p1    <= retire_fire ? head_e.old_phys : '0;
            commit_sys_p1   <= retire_fire && head_e.sys;
            commit_pc_p1    <= retire_fire ? head_e.pc : '0;
        end
    end

    assign rif.commit_valid    = commit_vld_p1;
    assign rif.commit_arch_reg = commit_arch_p1;
    assign rif.commit_new_phys = commit_new_p1;
    assign rif.commit_remap    = commit_remap_p1;
    assign rif.free_valid      = commit_remap_p1;
    assign rif.free_phys       = free_phys_p1;
    assign rif.commit_sys      = commit_sys_p1;
    assign rif.commit_pc       = commit_pc_p1;

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: retirements are scored against a queue of
// expected commits filled in allocation order.
module tb_rob_retire;

    logic clk;
    logic rst_n;
    logic flush;

    int n_cmp;
    int n_err;
    int n_commit;

    typedef struct {
        logic [4:0]  arch;
        logic [5:0]  newp;
        logic [5:0]  oldp;
        logic        remap;
        logic        sys;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    rob_retire_if #(.TAG_W(4), .PREG_W(6)) rif ();

    rob_retire #(.DEPTH(16), .TAG_W(4), .PREG_W(6)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .FLUSH (flush),
        .rif   (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every commit pulse must match the oldest outstanding allocation.
    always @(negedge clk) begin
        if (rst_n && rif.commit_valid) begin
            n_commit++;
            if (sb.size() == 0) begin
                check("commit_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("commit_pc",    64'(rif.commit_pc),       64'(mon_e.pc));
                check("commit_arch",  64'(rif.commit_arch_reg), 64'(mon_e.arch));
                check("commit_new",   64'(rif.commit_new_phys), 64'(mon_e.newp));
                check("commit_remap", 64'(rif.commit_remap),    64'(mon_e.remap));
                check("free_valid",   64'(rif.free_valid),      64'(mon_e.remap));
                check("commit_sys",   64'(rif.commit_sys),      64'(mon_e.sys));
                if (mon_e.remap)
                    check("free_phys", 64'(rif.free_phys), 64'(mon_e.oldp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic [4:0] arch, input logic [5:0] newp, input logic [5:0] oldp,
                            input logic regwr, input logic sys, input logic [31:0] pc,
                            input logic accept);
        exp_t e;
        rif.alloc_valid    = 1'b1;
        rif.alloc_arch_reg = arch;
        rif.alloc_new_phys = newp;
        rif.alloc_old_phys = oldp;
        rif.alloc_regwr    = regwr;
        rif.alloc_sys      = sys;
        rif.alloc_pc       = pc;
        if (accept) begin
            e.arch  = arch;
            e.newp  = newp;
            e.oldp  = oldp;
            e.remap = regwr && (arch != 5'd0);
            e.sys   = sys;
            e.pc    = pc;
            sb.push_back(e);
        end
        tick();
        rif.alloc_valid = 1'b0;
    endtask

    task automatic do_complete(input logic [3:0] tag);
        rif.complete_valid = 1'b1;
        rif.complete_tag   = tag;
        tick();
        rif.complete_valid = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        sb.delete();
        #2;
        check("rst_commit_valid", 64'(rif.commit_valid), 64'd0);
        check("rst_alloc_tag",    64'(rif.alloc_tag),    64'd0);
        check("rst_rob_halt",     64'(rif.rob_halt),     64'd0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        n_cmp = 0; n_err = 0; n_commit = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        rif.alloc_valid = 1'b0; rif.alloc_arch_reg = '0; rif.alloc_new_phys = '0;
        rif.alloc_old_phys = '0; rif.alloc_regwr = 1'b0; rif.alloc_sys = 1'b0;
        rif.alloc_pc = '0; rif.complete_valid = 1'b0; rif.complete_tag = '0;
        tick();

        // 1: single instruction round trip
        reset_dut();
        check("t1_head0", 64'(rif.head_tag), 64'd0);
        do_alloc(5'd5, 6'd33, 6'd5, 1'b1, 1'b0, 32'h0000_1000, 1'b1);
        check("t1_tail1", 64'(rif.alloc_tag), 64'd1);
        do_complete(4'd0);
        check("t1_latency", 64'(rif.commit_valid), 64'd0);
        tick();
        check("t1_commit_valid", 64'(rif.commit_valid),    64'd1);
        check("t1_commit_arch",  64'(rif.commit_arch_reg), 64'd5);
        check("t1_commit_new",   64'(rif.commit_new_phys), 64'd33);
        check("t1_free_valid",   64'(rif.free_valid),      64'd1);
        check("t1_free_phys",    64'(rif.free_phys),       64'd5);
        check("t1_head1",        64'(rif.head_tag),        64'd1);
        tick();
        check("t1_pulse_end", 64'({rif.commit_valid, rif.commit_arch_reg, rif.commit_new_phys,
                                   rif.commit_remap, rif.free_valid, rif.free_phys,
                                   rif.commit_sys, rif.commit_pc}), 64'd0);

        // 2: out-of-order completion, in-order retirement
        reset_dut();
        c0 = n_commit;
        do_alloc(5'd1, 6'd40, 6'd1, 1'b1, 1'b0, 32'h0000_2000, 1'b1);
        do_alloc(5'd2, 6'd41, 6'd2, 1'b1, 1'b1, 32'h0000_2004, 1'b1);
        do_alloc(5'd3, 6'd42, 6'd3, 1'b1, 1'b0, 32'h0000_2008, 1'b1);
        do_complete(4'd2);
        tick();
        check("t2_wait_a", 64'(rif.commit_valid), 64'd0);
        do_complete(4'd1);
        tick();
        check("t2_wait_b", 64'(rif.commit_valid), 64'd0);
        do_complete(4'd0);
        wait_drain("t2_drain");
        tick();
        check("t2_commit_count", 64'(n_commit - c0), 64'd3);
        check("t2_head3", 64'(rif.head_tag), 64'd3);

        // 3: full ROB back-pressure
        reset_dut();
        for (int k = 0; k < 16; k++) begin
            check("t3_alloc_tag", 64'(rif.alloc_tag), 64'(k));
            do_alloc(5'(k + 1), 6'(k + 16), 6'(k), 1'b1, 1'b0, 32'h3000 + 32'(k * 4), 1'b1);
        end
        check("t3_halt_full", 64'(rif.rob_halt),  64'd1);
        check("t3_tail_wrap", 64'(rif.alloc_tag), 64'd0);
        do_alloc(5'd9, 6'd63, 6'd9, 1'b1, 1'b0, 32'hDEAD_0000, 1'b0);
        check("t3_drop_tail", 64'(rif.alloc_tag), 64'd0);
        check("t3_drop_halt", 64'(rif.rob_halt),  64'd1);
        do_complete(4'd0);
        check("t3_halt_hold", 64'(rif.rob_halt),     64'd1);
        check("t3_no_commit", 64'(rif.commit_valid), 64'd0);
        tick();
        check("t3_retire",     64'(rif.commit_valid), 64'd1);
        check("t3_halt_drop",  64'(rif.rob_halt),     64'd0);
        check("t3_next_tag",   64'(rif.alloc_tag),    64'd0);
        check("t3_head1",      64'(rif.head_tag),     64'd1);
        tick();

        // 4: arch 0 retires without remap or free
        reset_dut();
        do_alloc(5'd0, 6'd50, 6'd7, 1'b1, 1'b1, 32'h0000_4000, 1'b1);
        do_complete(4'd0);
        tick();
        check("t4_commit_valid", 64'(rif.commit_valid), 64'd1);
        check("t4_remap",        64'(rif.commit_remap), 64'd0);
        check("t4_free_valid",   64'(rif.free_valid),   64'd0);
        check("t4_sys",          64'(rif.commit_sys),   64'd1);
        tick();

        // 5: flush with concurrent alloc
        reset_dut();
        for (int k = 0; k < 4; k++)
            do_alloc(5'(k + 10), 6'(k + 20), 6'(k + 10), 1'b1, 1'b0, 32'h5000 + 32'(k * 4), 1'b1);
        do_complete(4'd2);
        do_complete(4'd3);
        check("t5_pre_commit", 64'(rif.commit_valid), 64'd0);
        flush = 1'b1;
        rif.alloc_valid = 1'b1;
        rif.alloc_pc    = 32'hBAD0_0000;
        tick();
        flush = 1'b0;
        rif.alloc_valid = 1'b0;
        sb.delete();
        check("t5_tail0",   64'(rif.alloc_tag),    64'd0);
        check("t5_head0",   64'(rif.head_tag),     64'd0);
        check("t5_halt",    64'(rif.rob_halt),     64'd0);
        check("t5_commit0", 64'(rif.commit_valid), 64'd0);
        do_complete(4'd1);
        tick();
        check("t5_ignored", 64'(rif.commit_valid), 64'd0);
        check("t5_tail_still0", 64'(rif.alloc_tag), 64'd0);
        do_alloc(5'd4, 6'd44, 6'd4, 1'b1, 1'b0, 32'h0000_5100, 1'b1);
        check("t5_tail1", 64'(rif.alloc_tag), 64'd1);
        do_complete(4'd0);
        wait_drain("t5_drain");

        // 6: asynchronous reset during retirement
        reset_dut();
        do_alloc(5'd6, 6'd36, 6'd6, 1'b1, 1'b0, 32'h0000_6000, 1'b1);
        do_alloc(5'd7, 6'd37, 6'd7, 1'b1, 1'b0, 32'h0000_6004, 1'b1);
        do_complete(4'd0);
        do_complete(4'd1);
        check("t6_pre_commit", 64'(rif.commit_valid), 64'd1);
        check("t6_pre_pc",     64'(rif.commit_pc),    64'h0000_6000);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_async_commit", 64'(rif.commit_valid), 64'd0);
        check("t6_async_free",   64'(rif.free_valid),   64'd0);
        check("t6_async_pc",     64'(rif.commit_pc),    64'd0);
        check("t6_async_head",   64'(rif.head_tag),     64'd0);
        check("t6_async_tail",   64'(rif.alloc_tag),    64'd0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t6_no_commit", 64'(rif.commit_valid), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rob_retire.md
Name: rob_retire

Overview:
- In-order reorder buffer and retirement unit at the far end of the rename pipeline.
- Accepts one allocation per cycle from Rename and one completion per cycle from EXE.
- Retires at most one completed head entry per cycle:
  - pushes arch->phys commits to the RRAT;
  - returns the displaced physical register to Rename's free list (the rrat_free / rrat_free_reg path).
- Drives rob_halt back to Rename and exposes the head instruction number to Issue.

Parameters:
- DEPTH, 16, number of ROB entries; power of two, at least 2.
- TAG_W, 4, entry index width; equals log2(DEPTH).
- PREG_W, 6, physical register index width (64 physical registers).

Ports:
- CLK  input  1  clock.
- RESET  input  1  asynchronous active-low reset.
- FLUSH  input  1  squash all entries.
- alloc_valid  input  1  Rename allocates an entry this cycle.
- alloc_arch_reg  input  5  architectural destination (0 = none).
- alloc_new_phys  input  PREG_W  newly mapped physical register.
- alloc_old_phys  input  PREG_W  previous mapping of alloc_arch_reg.
- alloc_regwr  input  1  instruction writes a register.
- alloc_sys  input  1  instruction is a syscall.
- alloc_pc  input  32  instruction PC (debug).
- alloc_tag  output  TAG_W  index the current allocation receives; combinational, equals tail pointer.
- rob_halt  output  1  ROB full; Rename must not allocate.
- complete_valid  input  1  EXE reports completion.
- complete_tag  input  TAG_W  entry that completed.
- head_tag  output  TAG_W  oldest entry index (Issue rob_instr_num).
- commit_valid  output  1  one retirement occurred.
- commit_arch_reg  output  5  RRAT reg_to_map.
- commit_new_phys  output  PREG_W  RRAT new_mapping.
- commit_remap  output  1  RRAT remap strobe: commit_valid & regwr & arch_reg!=0.
- free_valid  output  1  return_map to Rename.
- free_phys  output  PREG_W  returned_mapping (old phys).
- commit_sys  output  1  retired instruction was a syscall.
- commit_pc  output  32  retired PC (debug).

Behaviour:
- Storage per entry: valid, done, arch_reg, new_phys, old_phys, regwr, sys, pc.
- Pointers: head and tail, TAG_W bits each, wrap modulo DEPTH. count is TAG_W+1 bits.
- Reset (RESET low, async):
  - all valid/done cleared; head = tail = count = 0;
  - every registered output 0; rob_halt 0.
- rob_halt is combinational: count == DEPTH.
- Allocate (alloc_valid & !rob_halt):
  - write entry[tail] with valid=1, done=0;
  - tail+1.
  - alloc_valid while rob_halt is dropped; no state change.
- Complete (complete_valid & entry[complete_tag].valid):
  - set done.
  - Completion to an invalid entry is ignored.
  - Completion to an entry being retired the same cycle is harmless.
- Retire, evaluated on state before the edge (entry[head].valid & done):
  - clear entry[head].valid; head+1.
  - Register the commit outputs; they are valid for exactly one cycle after the edge.
  - free_valid = commit_remap; free_phys = old_phys.
  - Without retire, all commit/free outputs are 0 the next cycle.
- Latency: completion sampled at edge N; earliest commit_valid is high during cycle N+1 to N+2. An entry allocated at edge N can retire no earlier than edge N+2.
- count: +1 on accepted alloc, -1 on retire, unchanged when both happen.
  - Full with a retire in the same cycle: rob_halt is still high that cycle, so no alloc.
  - Empty: retire never fires.
- alloc_arch_reg = 0 or alloc_regwr = 0: entry still occupies a slot and retires in order; commit_remap = 0, free_valid = 0.
- Syscall: retires normally with commit_sys = 1 for one cycle. The ROB does not stall on it.
- FLUSH:
  - highest priority; synchronous at the edge;
  - clears all valid/done; head = tail = count = 0;
  - commit/free outputs 0 next cycle;
  - concurrent alloc, complete and retire are discarded.
- RESET asserted mid-operation: immediately clears everything, overriding any in-flight retire.

Decomposition:
- Shared package holds:
  - the ROB entry struct (field order as listed under Behaviour);
  - PREG_W and the physical register count;
  - the ARCH_ZERO constant.
- One natural sub-module: rob_ptr_ctr, a wrap-around pointer with increment enable and synchronous clear. Instantiate it twice, for head and tail.

Test Plan:
1. Reset, then alloc tag0 (arch 5, new 33, old 5, regwr), complete tag0 -> next cycle commit_valid=1, commit_arch_reg=5, commit_new_phys=33, free_valid=1, free_phys=5, head_tag=1.
2. Alloc tags 0,1,2; complete in order 2,1,0 -> exactly three commit pulses, in tag order 0,1,2, none before tag0 completes.
3. Alloc 16 entries -> rob_halt=1. A 17th alloc_valid is dropped (tail stays 0). Complete tag0 -> one retire, rob_halt drops the following cycle, next alloc_tag=0.
4. Alloc with arch_reg=0 and regwr=1, complete it -> commit_valid=1, commit_remap=0, free_valid=0.
5. Alloc 4 entries, complete 2, assert FLUSH with a simultaneous alloc -> count=0, head=tail=0, no commit pulse; a later complete_tag=1 is ignored.
6. Pull RESET low while head is done -> outputs 0 immediately; no commit is emitted after release.
